// File: rtl/asip_img_pkg.sv
// Shared types and frame geometry for the ASIP frame-memory scan path.
package asip_img_pkg;

  localparam int IMG_WIDTH  = 320;
  localparam int IMG_HEIGHT = 240;
  localparam int COLOR_BITS = 8;
  localparam int X_BITS     = 9;
  localparam int Y_BITS     = 8;

  typedef struct packed {
    logic [COLOR_BITS-1:0] r;
    logic [COLOR_BITS-1:0] g;
    logic [COLOR_BITS-1:0] b;
  } rgb_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_WAIT = 3'd2,
    ISSUE   = 3'd3,
    COLLECT = 3'd4,
    WRITE   = 3'd5
  } scan_state_t;

endpackage

// File: rtl/image_scan_ctrl_if.sv
// Frame-memory read/write ports plus the pixel/result handshakes of the scan sequencer.
interface image_scan_ctrl_if #(
  parameter int CBITS = asip_img_pkg::COLOR_BITS
) ();
  import asip_img_pkg::*;

  logic [X_BITS-1:0] rd_x;
  logic [Y_BITS-1:0] rd_y;
  logic [CBITS-1:0]  rd_r, rd_g, rd_b;

  logic              wr_en;
  logic [X_BITS-1:0] wr_x;
  logic [Y_BITS-1:0] wr_y;
  logic [CBITS-1:0]  wr_r, wr_g, wr_b;

  logic              pix_valid, pix_ready;
  logic [X_BITS-1:0] pix_x;
  logic [Y_BITS-1:0] pix_y;
  logic [CBITS-1:0]  pix_r, pix_g, pix_b;

  logic              res_valid, res_ready;
  logic [CBITS-1:0]  res_r, res_g, res_b;

  modport master (
    output rd_x, rd_y,
    input  rd_r, rd_g, rd_b,
    output wr_en, wr_x, wr_y, wr_r, wr_g, wr_b,
    output pix_valid, pix_x, pix_y, pix_r, pix_g, pix_b,
    input  pix_ready,
    input  res_valid, res_r, res_g, res_b,
    output res_ready
  );

  modport slave (
    input  rd_x, rd_y,
    output rd_r, rd_g, rd_b,
    input  wr_en, wr_x, wr_y, wr_r, wr_g, wr_b,
    input  pix_valid, pix_x, pix_y, pix_r, pix_g, pix_b,
    output pix_ready,
    output res_valid, res_r, res_g, res_b,
    input  res_ready
  );

endinterface

// File: rtl/image_scan_ctrl_raster_counter.sv
// Row-major x/y pixel counter; wraps x at WIDTH-1 and y at HEIGHT-1.
module raster_counter #(
  parameter int WIDTH  = asip_img_pkg::IMG_WIDTH,
  parameter int HEIGHT = asip_img_pkg::IMG_HEIGHT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic                           advance,
  output logic [asip_img_pkg::X_BITS-1:0] x,
  output logic [asip_img_pkg::Y_BITS-1:0] y,
  output logic                           last
);
  import asip_img_pkg::*;

  logic [X_BITS-1:0] x_q, x_d;
  logic [Y_BITS-1:0] y_q, y_d;
  logic              x_end, y_end;

  assign x_end = (x_q == X_BITS'(WIDTH - 1));
  assign y_end = (y_q == Y_BITS'(HEIGHT - 1));

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear) begin
      x_d = '0;
      y_d = '0;
    end else if (advance) begin
      if (x_end) begin
        x_d = '0;
        y_d = y_end ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign last = x_end && y_end;

endmodule

// File: rtl/image_scan_ctrl.sv
// Raster-scan sequencer: read pixel, hand to processing unit, write result back, one pixel in flight.
// IDLE wait start | RD_ADDR drive addr | RD_WAIT latch read | ISSUE offer pixel | COLLECT take result | WRITE write back
module image_scan_ctrl #(
  parameter int WIDTH      = asip_img_pkg::IMG_WIDTH,
  parameter int HEIGHT     = asip_img_pkg::IMG_HEIGHT,
  parameter int COLOR_BITS = asip_img_pkg::COLOR_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  image_scan_ctrl_if.master bus
);
  import asip_img_pkg::*;

  typedef struct packed {
    logic [COLOR_BITS-1:0] r;
    logic [COLOR_BITS-1:0] g;
    logic [COLOR_BITS-1:0] b;
  } px_t;

  scan_state_t       state_q, state_d;
  px_t               pix_q, pix_d;
  px_t               res_q, res_d;
  logic              done_q, done_d;
  logic              cnt_clear, cnt_advance, cnt_last;
  logic [X_BITS-1:0] cur_x;
  logic [Y_BITS-1:0] cur_y;

  raster_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (cnt_clear),
    .advance (cnt_advance),
    .x       (cur_x),
    .y       (cur_y),
    .last    (cnt_last)
  );

  always_comb begin
    state_d     = state_q;
    pix_d       = pix_q;
    res_d       = res_q;
    done_d      = 1'b0;
    cnt_clear   = 1'b0;
    cnt_advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          cnt_clear = 1'b1;
          state_d   = RD_ADDR;
        end
      end
      RD_ADDR: state_d = RD_WAIT;
      RD_WAIT: begin
        pix_d   = '{r: bus.rd_r, g: bus.rd_g, b: bus.rd_b};
        state_d = ISSUE;
      end
      ISSUE: begin
        if (bus.pix_ready) state_d = COLLECT;
      end
      COLLECT: begin
        if (bus.res_valid) begin
          res_d   = '{r: bus.res_r, g: bus.res_g, b: bus.res_b};
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (cnt_last) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_advance = 1'b1;
          state_d     = RD_ADDR;
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides every transition; a write already on the bus this cycle still lands.
    if (abort && state_q != IDLE) begin
      state_d     = IDLE;
      done_d      = 1'b0;
      cnt_advance = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pix_q   <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;

  assign bus.rd_x = busy ? cur_x : '0;
  assign bus.rd_y = busy ? cur_y : '0;

  assign bus.wr_en = (state_q == WRITE);
  assign bus.wr_x  = cur_x;
  assign bus.wr_y  = cur_y;
  assign bus.wr_r  = res_q.r;
  assign bus.wr_g  = res_q.g;
  assign bus.wr_b  = res_q.b;

  assign bus.pix_valid = (state_q == ISSUE);
  assign bus.pix_x     = cur_x;
  assign bus.pix_y     = cur_y;
  assign bus.pix_r     = pix_q.r;
  assign bus.pix_g     = pix_q.g;
  assign bus.pix_b     = pix_q.b;

  assign bus.res_ready = (state_q == COLLECT);

endmodule

// File: tb/tb_image_scan_ctrl.sv
// Directed bench for image_scan_ctrl: a 4x3 frame with inverting processing unit plus a default-size instance.
module tb_image_scan_ctrl;
  import asip_img_pkg::*;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, abort = 1'b0, busy, done;
  logic big_start = 1'b0, big_abort = 1'b0, big_busy, big_done;

  int n_cmp = 0;
  int n_err = 0;

  image_scan_ctrl_if #(.CBITS(8)) sif ();
  image_scan_ctrl_if #(.CBITS(8)) bif ();

  image_scan_ctrl #(.WIDTH(W), .HEIGHT(H), .COLOR_BITS(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy), .done(done), .bus(sif)
  );

  image_scan_ctrl big (
    .clk(clk), .rst(rst), .start(big_start), .abort(big_abort),
    .busy(big_busy), .done(big_done), .bus(bif)
  );

  always #5 clk = ~clk;

  // Small frame memory, 1-cycle registered read, write-back on wr_en
  rgb_t mem [N];
  logic preload_req = 1'b0;

  always @(posedge clk) begin
    int ridx, widx;
    ridx = int'(sif.rd_y) * W + int'(sif.rd_x);
    widx = int'(sif.wr_y) * W + int'(sif.wr_x);
    if (ridx < N) {sif.rd_r, sif.rd_g, sif.rd_b} <= mem[ridx];
    if (preload_req) begin
      for (int i = 0; i < N; i++) mem[i] <= {3{8'(i)}};
    end else if (sif.wr_en && widx < N) begin
      mem[widx] <= {sif.wr_r, sif.wr_g, sif.wr_b};
    end
  end

  assign sif.res_valid = 1'b1;
  assign sif.res_r = ~sif.pix_r;
  assign sif.res_g = ~sif.pix_g;
  assign sif.res_b = ~sif.pix_b;

  // Default-size instance: read data is r=x[7:0], g=y, b=0
  always @(posedge clk) begin
    bif.rd_r <= bif.rd_x[7:0];
    bif.rd_g <= bif.rd_y;
    bif.rd_b <= 8'd0;
  end
  assign bif.pix_ready = 1'b1;
  assign bif.res_valid = 1'b1;
  assign bif.res_r = ~bif.pix_r;
  assign bif.res_g = ~bif.pix_g;
  assign bif.res_b = ~bif.pix_b;

  typedef struct {
    int   x;
    int   y;
    rgb_t c;
  } wr_t;
  wr_t wlog [$];

  always @(negedge clk) begin
    wr_t e;
    if (sif.wr_en) begin
      e.x = int'(sif.wr_x);
      e.y = int'(sif.wr_y);
      e.c = {sif.wr_r, sif.wr_g, sif.wr_b};
      wlog.push_back(e);
    end
  end

  task automatic preload();
    preload_req = 1'b1;
    @(negedge clk);
    preload_req = 1'b0;
  endtask

  // Pulses start and runs until done; optional stall on pixel (2,1) and a stray start at (1,0).
  task automatic run_frame(input int stall_n, input bit inj_start,
                           output int cycles, output int stalled, output int stall_bad);
    int n;
    wlog.delete();
    stalled = 0;
    stall_bad = 0;
    cycles = -1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (n <= 2000) begin
      if (done) begin
        cycles = n;
        break;
      end
      start = 1'b0;
      sif.pix_ready = 1'b1;
      if (inj_start && sif.pix_valid && sif.pix_x == 9'd1 && sif.pix_y == 8'd0) start = 1'b1;
      if (stall_n > 0 && sif.pix_valid && sif.pix_x == 9'd2 && sif.pix_y == 8'd1 && stalled < stall_n) begin
        sif.pix_ready = 1'b0;
        stalled++;
        if (sif.pix_r !== 8'd6 || sif.pix_g !== 8'd6 || sif.pix_b !== 8'd6 ||
            sif.res_ready !== 1'b0 || busy !== 1'b1) stall_bad++;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    sif.pix_ready = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({busy, done, sif.wr_en, sif.pix_valid, sif.res_ready} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b need 00000", {busy, done, sif.wr_en, sif.pix_valid, sif.res_ready});
    end
    n_cmp++;
    if ({sif.rd_x, sif.rd_y, sif.wr_x, sif.wr_y, sif.pix_r} !== '0) begin
      n_err++;
      $display("FAIL reset_addr: rd=(%0d,%0d) wr=(%0d,%0d) pix_r=%0d need all 0",
               sif.rd_x, sif.rd_y, sif.wr_x, sif.wr_y, sif.pix_r);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_start_abort_idle();
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || sif.rd_x !== 9'd0) begin
      n_err++;
      $display("FAIL start_abort_idle: busy=%b rd_x=%0d need busy=0 rd_x=0", busy, sif.rd_x);
    end
    @(negedge clk);
  endtask

  task automatic test_frame();
    int cyc, st, sb;
    preload();
    run_frame(0, 1'b0, cyc, st, sb);
    n_cmp++;
    if (cyc !== 61) begin
      n_err++;
      $display("FAIL frame_done_cycle: got %0d need 61", cyc);
    end
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (i >= wlog.size()) begin
        n_err++;
        $display("FAIL frame_wr%0d: missing, need (%0d,%0d)=%0d", i, i % W, i / W, 255 - i);
      end else if (wlog[i].x !== i % W || wlog[i].y !== i / W || wlog[i].c !== {3{8'(255 - i)}}) begin
        n_err++;
        $display("FAIL frame_wr%0d: got (%0d,%0d)=%h need (%0d,%0d)=%0d",
                 i, wlog[i].x, wlog[i].y, wlog[i].c, i % W, i / W, 255 - i);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || wlog.size() != N) begin
      n_err++;
      $display("FAIL frame_after: done=%b busy=%b writes=%0d need 0 0 %0d", done, busy, wlog.size(), N);
    end
  endtask

  task automatic test_start_ignored();
    int cyc, st, sb;
    preload();
    run_frame(0, 1'b1, cyc, st, sb);
    n_cmp++;
    if (cyc !== 61) begin
      n_err++;
      $display("FAIL restart_done_cycle: got %0d need 61", cyc);
    end
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (i >= wlog.size()) begin
        n_err++;
        $display("FAIL restart_wr%0d: missing", i);
      end else if (wlog[i].x !== i % W || wlog[i].y !== i / W || wlog[i].c !== {3{8'(255 - i)}}) begin
        n_err++;
        $display("FAIL restart_wr%0d: got (%0d,%0d)=%h need (%0d,%0d)=%0d",
                 i, wlog[i].x, wlog[i].y, wlog[i].c, i % W, i / W, 255 - i);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int cyc, st, sb;
    preload();
    run_frame(7, 1'b0, cyc, st, sb);
    n_cmp++;
    if (cyc !== 68) begin
      n_err++;
      $display("FAIL bp_done_cycle: got %0d need 68", cyc);
    end
    n_cmp++;
    if (st !== 7 || sb !== 0) begin
      n_err++;
      $display("FAIL bp_stall: stalled=%0d unstable=%0d need 7 and 0", st, sb);
    end
    n_cmp++;
    if (wlog.size() != N || wlog[6].x !== 2 || wlog[6].y !== 1 || wlog[6].c !== {3{8'd249}}) begin
      n_err++;
      $display("FAIL bp_writes: count=%0d need %0d with (2,1)=249", wlog.size(), N);
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    bit hit;
    int done_seen;
    preload();
    wlog.delete();
    hit = 1'b0;
    done_seen = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (sif.res_ready && sif.pix_x == 9'd3 && sif.pix_y == 8'd0) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_cmp++;
    if (!hit || busy !== 1'b0 || sif.res_ready !== 1'b0 || sif.wr_en !== 1'b0) begin
      n_err++;
      $display("FAIL abort_idle: reached=%0d busy=%b res_ready=%b wr_en=%b need 1 0 0 0",
               hit, busy, sif.res_ready, sif.wr_en);
    end
    repeat (4) begin
      if (done) done_seen++;
      @(negedge clk);
    end
    n_cmp++;
    if (done_seen != 0 || wlog.size() != 3) begin
      n_err++;
      $display("FAIL abort_no_done: done_pulses=%0d writes=%0d need 0 and 3", done_seen, wlog.size());
    end
    n_cmp++;
    if (mem[0] !== {3{8'd255}} || mem[1] !== {3{8'd254}} || mem[2] !== {3{8'd253}} || mem[3] !== {3{8'd3}}) begin
      n_err++;
      $display("FAIL abort_mem: got %h %h %h %h need ffffff fefefe fdfdfd 030303",
               mem[0], mem[1], mem[2], mem[3]);
    end
  endtask

  task automatic test_async_reset();
    bit hit;
    int cyc, st, sb;
    preload();
    wlog.delete();
    hit = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (sif.wr_en && sif.wr_x == 9'd0 && sif.wr_y == 8'd1) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (!hit || sif.wr_en !== 1'b0 || busy !== 1'b0 || sif.pix_valid !== 1'b0 || sif.rd_x !== 9'd0) begin
      n_err++;
      $display("FAIL async_rst: reached=%0d wr_en=%b busy=%b pix_valid=%b rd_x=%0d need 1 0 0 0 0",
               hit, sif.wr_en, busy, sif.pix_valid, sif.rd_x);
    end
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (mem[4] !== {3{8'd4}}) begin
      n_err++;
      $display("FAIL async_rst_nowrite: mem(0,1)=%h need 040404", mem[4]);
    end
    preload();
    run_frame(0, 1'b0, cyc, st, sb);
    n_cmp++;
    if (cyc !== 61 || wlog.size() != N || wlog[0].x !== 0 || wlog[0].y !== 0 || wlog[0].c !== {3{8'd255}}) begin
      n_err++;
      $display("FAIL async_rst_restart: cycles=%0d writes=%0d need 61 and %0d starting (0,0)=255",
               cyc, wlog.size(), N);
    end
    @(negedge clk);
  endtask

  task automatic test_default_size();
    int k;
    bit got319, got320;
    k = 0;
    got319 = 1'b0;
    got320 = 1'b0;
    big_start = 1'b1;
    @(negedge clk);
    big_start = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (bif.wr_en) begin
        if (k == 319) begin
          got319 = 1'b1;
          n_cmp++;
          if (bif.wr_x !== 9'd319 || bif.wr_y !== 8'd0 || {bif.wr_r, bif.wr_g, bif.wr_b} !== 24'hc0ffff) begin
            n_err++;
            $display("FAIL big_row_end: got (%0d,%0d)=%h need (319,0)=c0ffff",
                     bif.wr_x, bif.wr_y, {bif.wr_r, bif.wr_g, bif.wr_b});
          end
        end else if (k == 320) begin
          got320 = 1'b1;
          n_cmp++;
          if (bif.wr_x !== 9'd0 || bif.wr_y !== 8'd1 || {bif.wr_r, bif.wr_g, bif.wr_b} !== 24'hfffeff) begin
            n_err++;
            $display("FAIL big_row_wrap: got (%0d,%0d)=%h need (0,1)=fffeff",
                     bif.wr_x, bif.wr_y, {bif.wr_r, bif.wr_g, bif.wr_b});
          end
          break;
        end
        k++;
      end
      @(negedge clk);
    end
    big_abort = 1'b1;
    @(negedge clk);
    big_abort = 1'b0;
    n_cmp++;
    if (!got319 || !got320 || big_busy !== 1'b0 || big_done !== 1'b0) begin
      n_err++;
      $display("FAIL big_abort: saw319=%0d saw320=%0d busy=%b done=%b need 1 1 0 0",
               got319, got320, big_busy, big_done);
    end
  endtask

  initial begin
    sif.pix_ready = 1'b1;
    test_reset();
    test_start_abort_idle();
    test_frame();
    test_start_ignored();
    test_backpressure();
    test_abort();
    test_async_reset();
    test_default_size();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
